// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, pad FSM states and byte-lane write helper
package sha256_pkg;

  localparam int SHA_BLK_BITS   = 512;
  localparam int MSG_BUF_BITS   = 1024;
  localparam int LEN_FIELD_BITS = 64;
  localparam int PAD_MAX_BYTES  = 119;

  typedef enum logic [1:0] {
    ABSORB,
    PAD,
    OUT,
    DROP
  } pad_state_e;

  // Lane 0 is the most significant byte of the buffer (big-endian packing).
  function automatic logic [MSG_BUF_BITS-1:0] put_byte(
    input logic [MSG_BUF_BITS-1:0] buf_in,
    input logic [6:0]              lane,
    input logic [7:0]              data
  );
    logic [MSG_BUF_BITS-1:0] r;
    r = buf_in;
    r[MSG_BUF_BITS-1-8*int'(lane) -: 8] = data;
    return r;
  endfunction

endpackage

// File: rtl/sha256_msg_pad_if.sv
// rtl/sha256_msg_pad_if.sv - byte input stream and padded-block output handshake
interface sha256_msg_pad_if
  import sha256_pkg::*;
;
  logic [7:0]              in_data;
  logic                    in_last;
  logic                    in_valid;
  logic                    in_ready;
  logic [MSG_BUF_BITS-1:0] out;
  logic [4:0]              msg_len_o;
  logic                    two_blk_o;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_o;

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out, msg_len_o, two_blk_o, out_valid, err_o
  );

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out, msg_len_o, two_blk_o, out_valid, err_o
  );

endinterface

// File: rtl/sha256_msg_pad.sv
// rtl/sha256_msg_pad.sv - packs a byte stream into a 1024-bit buffer with SHA-256 padding
module sha256_msg_pad
  import sha256_pkg::*;
#(
  parameter int MAX_BYTES = PAD_MAX_BYTES,
  parameter int BLK_BITS  = MSG_BUF_BITS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sha256_msg_pad_if.slave  bus
);

  pad_state_e          state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [6:0]          len_q, len_d;
  logic [BLK_BITS-1:0] buf_q, buf_d;
  logic                two_blk_q, two_blk_d;
  logic [4:0]          msg_len_q, msg_len_d;
  logic                err_q, err_d;

  logic                in_ready;
  logic                accept;
  logic [63:0]         len_bits;

  assign in_ready = (state_q == ABSORB) || (state_q == DROP);
  assign accept   = bus.in_valid && in_ready;
  assign len_bits = {54'd0, len_q, 3'd0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    buf_d     = buf_q;
    two_blk_d = two_blk_q;
    msg_len_d = msg_len_q;
    err_d     = 1'b0;

    case (state_q)
      ABSORB: begin
        if (accept) begin
          // A byte arriving with the buffer already full cannot be padded: overflow.
          if (cnt_q == 7'(MAX_BYTES)) begin
            if (bus.in_last) begin
              err_d = 1'b1;
              buf_d = '0;
              cnt_d = '0;
            end else begin
              state_d = DROP;
            end
          end else begin
            buf_d = put_byte(buf_q, cnt_q, bus.in_data);
            cnt_d = cnt_q + 7'd1;
            if (bus.in_last) begin
              len_d   = cnt_q + 7'd1;
              state_d = PAD;
            end
          end
        end
      end

      PAD: begin
        buf_d = put_byte(buf_q, len_q, 8'h80);
        if (len_q <= 7'd55) begin
          buf_d[SHA_BLK_BITS+LEN_FIELD_BITS-1:SHA_BLK_BITS] = len_bits;
          two_blk_d = 1'b0;
        end else begin
          buf_d[LEN_FIELD_BITS-1:0] = len_bits;
          two_blk_d = 1'b1;
        end
        msg_len_d = 5'((len_q + 7'd3) >> 2);
        state_d   = OUT;
      end

      OUT: begin
        if (bus.out_ready) begin
          buf_d     = '0;
          cnt_d     = '0;
          len_d     = '0;
          two_blk_d = 1'b0;
          msg_len_d = '0;
          state_d   = ABSORB;
        end
      end

      DROP: begin
        if (accept && bus.in_last) begin
          err_d   = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ABSORB;
        end
      end

      default: state_d = ABSORB;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ABSORB;
      cnt_q     <= '0;
      len_q     <= '0;
      buf_q     <= '0;
      two_blk_q <= 1'b0;
      msg_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      buf_q     <= buf_d;
      two_blk_q <= two_blk_d;
      msg_len_q <= msg_len_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = buf_q;
  assign bus.msg_len_o = msg_len_q;
  assign bus.two_blk_o = two_blk_q;
  assign bus.out_valid = (state_q == OUT);
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_sha256_msg_pad.sv
// tb/tb_sha256_msg_pad.sv - directed self-checking bench for sha256_msg_pad
module tb_sha256_msg_pad;
  import sha256_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_pad_if ifc ();

  sha256_msg_pad dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (ifc)
  );

  int checks = 0;
  int passed = 0;
  int err_cnt = 0;
  int ov_cnt  = 0;
  logic [7:0]    msg [0:127];
  logic [1023:0] e;
  int e0, v0;

  always @(negedge clk) begin
    if (ifc.err_o)     err_cnt++;
    if (ifc.out_valid) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_buf(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int k;
    k = -1;
    for (int j = 15; j >= 0; j--)
      if (k < 0 && obs[j*64 +: 64] !== exp[j*64 +: 64]) k = j;
    if (k < 0) k = 0;
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s out[%0d+:64] observed=%h expected=%h", tag, k*64, obs[k*64 +: 64], exp[k*64 +: 64]);
  endtask

  // Drives n bytes from msg[], one per cycle; returns at the negedge after the last accept.
  task automatic send_msg(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_data  = msg[i];
      ifc.in_last  = with_last && (i == n - 1);
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.in_data  = 8'h00;
  endtask

  task automatic handshake(input string tag);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk({tag, "_in_ready_back"}, 64'(ifc.in_ready), 64'd1);
    chk({tag, "_valid_drop"}, 64'(ifc.out_valid), 64'd0);
    chk_buf({tag, "_cleared"}, ifc.out, '0);
  endtask

  task automatic expect_abc(input string tag);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 1'b1);
    chk({tag, "_n1_valid"}, 64'(ifc.out_valid), 64'd0);
    chk({tag, "_n1_ready"}, 64'(ifc.in_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_n2_valid"}, 64'(ifc.out_valid), 64'd1);
    e = '0;
    e[1023:992] = 32'h61626380;
    e[575:512]  = 64'h18;
    chk_buf({tag, "_out"}, ifc.out, e);
    chk({tag, "_two_blk"}, 64'(ifc.two_blk_o), 64'd0);
    chk({tag, "_msg_len"}, 64'(ifc.msg_len_o), 64'd1);
    handshake(tag);
  endtask

  initial begin
    ifc.in_data   = 8'h00;
    ifc.in_last   = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_err", 64'(ifc.err_o), 64'd0);
    chk("rst_msg_len", 64'(ifc.msg_len_o), 64'd0);
    chk("rst_two_blk", 64'(ifc.two_blk_o), 64'd0);
    chk_buf("rst_out", ifc.out, '0);
    rst_n = 1'b1;

    expect_abc("abc");

    // 56 bytes: first length that needs the second block
    for (int i = 0; i < 56; i++) msg[i] = 8'(i);
    send_msg(56, 1'b1);
    @(negedge clk);
    chk("b56_valid", 64'(ifc.out_valid), 64'd1);
    e = '0;
    for (int i = 0; i < 56; i++) e[1023-8*i -: 8] = 8'(i);
    e[575:568] = 8'h80;
    e[63:0]    = 64'h1C0;
    chk_buf("b56_out", ifc.out, e);
    chk("b56_two_blk", 64'(ifc.two_blk_o), 64'd1);
    chk("b56_msg_len", 64'(ifc.msg_len_o), 64'd14);
    handshake("b56");

    // 119 bytes: largest legal message
    e0 = err_cnt;
    for (int i = 0; i < 119; i++) msg[i] = 8'hAA;
    send_msg(119, 1'b1);
    @(negedge clk);
    chk("b119_valid", 64'(ifc.out_valid), 64'd1);
    e = '0;
    for (int i = 0; i < 119; i++) e[1023-8*i -: 8] = 8'hAA;
    e[71:64] = 8'h80;
    e[63:0]  = 64'h3B8;
    chk_buf("b119_out", ifc.out, e);
    chk("b119_two_blk", 64'(ifc.two_blk_o), 64'd1);
    chk("b119_msg_len", 64'(ifc.msg_len_o), 64'd30);
    chk("b119_no_err", 64'(err_cnt - e0), 64'd0);
    handshake("b119");

    // 125 bytes: overflow, dropped with one err pulse
    e0 = err_cnt;
    v0 = ov_cnt;
    for (int i = 0; i < 125; i++) msg[i] = 8'(i + 3);
    send_msg(125, 1'b1);
    chk("ovf_err_pulse", 64'(ifc.err_o), 64'd1);
    @(negedge clk);
    chk("ovf_err_clear", 64'(ifc.err_o), 64'd0);
    chk("ovf_in_ready", 64'(ifc.in_ready), 64'd1);
    @(negedge clk);
    chk("ovf_err_count", 64'(err_cnt - e0), 64'd1);
    chk("ovf_no_valid", 64'(ov_cnt - v0), 64'd0);
    expect_abc("post_ovf");

    // Downstream stall for 6 cycles
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 1'b1);
    @(negedge clk);
    e = '0;
    e[1023:992] = 32'h61626380;
    e[575:512]  = 64'h18;
    for (int c = 0; c < 6; c++) begin
      chk("stall_valid", 64'(ifc.out_valid), 64'd1);
      chk("stall_in_ready", 64'(ifc.in_ready), 64'd0);
      chk_buf("stall_out", ifc.out, e);
      chk("stall_msg_len", 64'(ifc.msg_len_o), 64'd1);
      chk("stall_two_blk", 64'(ifc.two_blk_o), 64'd0);
      @(negedge clk);
    end
    handshake("stall");

    // Back-to-back 4-byte message must carry no residue
    msg[0] = 8'h01; msg[1] = 8'h02; msg[2] = 8'h03; msg[3] = 8'h04;
    send_msg(4, 1'b1);
    @(negedge clk);
    chk("b4_valid", 64'(ifc.out_valid), 64'd1);
    e = '0;
    e[1023:992] = 32'h01020304;
    e[991:984]  = 8'h80;
    e[575:512]  = 64'h20;
    chk_buf("b4_out", ifc.out, e);
    chk("b4_msg_len", 64'(ifc.msg_len_o), 64'd1);
    chk("b4_two_blk", 64'(ifc.two_blk_o), 64'd0);
    handshake("b4");

    // Asynchronous reset mid-message
    for (int i = 0; i < 10; i++) msg[i] = 8'hC0 + 8'(i);
    send_msg(10, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk_buf("arst_out", ifc.out, '0);
    chk("arst_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("arst_valid", 64'(ifc.out_valid), 64'd0);
    chk("arst_msg_len", 64'(ifc.msg_len_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_abc("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
